// File: rtl/fir_host_driver.sv
// ----------------------------------------------------------------------------
// fir_host_driver
//
// Host-side initiator for a FIR filter core. It keeps a local coefficient
// buffer, replays it to the FIR as a configuration burst, then feeds input
// samples one at a time (enable pulse, wait for done, return the result).
//
// Ports
//   clk / rst_n                  clock (rising edge) and async active-low reset
//   coef_we_i/addr_i/wdata_i     coefficient buffer write port
//   tap_count_i, cfg_start_i     (re)configuration request and tap count
//   s_valid_i/s_data_i/s_ready_o input sample handshake
//   fir_data_in_o, fir_enable_o,
//   fir_configuration_o,
//   fir_config_data_enable_o     registered drive of the FIR core pins
//   fir_data_out_i,
//   fir_overflow_flag_i,
//   fir_done_i                   FIR core response
//   r_valid_o/r_data_o/r_ovf_o   one-cycle result strobe with data and overflow
//   configured_o                 FIR holds a valid configuration
//   cfg_err_o                    pulse: cfg_start rejected for a bad tap count
//   timeout_err_o                sticky: FIR never answered a sample
// ----------------------------------------------------------------------------
module fir_host_driver #(
    parameter int MAX_TAPS = 16,
    parameter int AW       = 4,
    parameter int TIMEOUT  = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          coef_we_i,
    input  logic [AW-1:0] coef_addr_i,
    input  logic [7:0]    coef_wdata_i,
    input  logic [4:0]    tap_count_i,
    input  logic          cfg_start_i,
    input  logic          s_valid_i,
    input  logic [7:0]    s_data_i,
    output logic          s_ready_o,
    output logic [7:0]    fir_data_in_o,
    output logic          fir_enable_o,
    output logic          fir_configuration_o,
    output logic          fir_config_data_enable_o,
    input  logic [7:0]    fir_data_out_i,
    input  logic [1:0]    fir_overflow_flag_i,
    input  logic          fir_done_i,
    output logic          r_valid_o,
    output logic [7:0]    r_data_o,
    output logic [1:0]    r_ovf_o,
    output logic          configured_o,
    output logic          cfg_err_o,
    output logic          timeout_err_o
);

    // One counter serves the setup/guard phases, the coefficient index and
    // the done timeout, so it must be wide enough for the largest of them.
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int CW = (TW > AW + 1) ? TW : AW + 1;

    typedef enum logic [3:0] {
        IDLE,
        CFG_SETUP,
        CFG_HDR,
        CFG_COEF,
        CFG_GUARD,
        READY,
        SAMPLE,
        WAIT_DONE,
        RESULT
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]    taps_q, taps_d;
    logic          configured_q, configured_d;
    logic          timeout_q, timeout_d;
    logic          cfg_err_q, cfg_err_d;
    logic          r_valid_q, r_valid_d;
    logic [7:0]    r_data_q, r_data_d;
    logic [1:0]    r_ovf_q, r_ovf_d;
    logic [7:0]    din_q, din_d;
    logic          en_q, en_d;
    logic          cfg_q, cfg_d;
    logic          cde_q, cde_d;

    logic [7:0]    coef_buf_q [MAX_TAPS];

    logic          taps_ok;
    logic          cfg_accept;
    logic          take_sample;
    logic          buf_locked;

    assign taps_ok     = (tap_count_i != 5'd0) && (int'(tap_count_i) <= MAX_TAPS);
    assign cfg_accept  = cfg_start_i && taps_ok && ((state_q == IDLE) || (state_q == READY));
    // A rejected cfg_start does not block a sample offered in the same cycle.
    assign take_sample = (state_q == READY) && s_valid_i && !cfg_accept;
    // The buffer is frozen while its contents are on the wire.
    assign buf_locked  = (state_q == CFG_HDR) || (state_q == CFG_COEF);

    // Coefficient storage has no reset; its contents are undefined until written.
    always_ff @(posedge clk) begin
        if (coef_we_i && !buf_locked) begin
            coef_buf_q[coef_addr_i] <= coef_wdata_i;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        taps_d       = taps_q;
        configured_d = configured_q;
        timeout_d    = timeout_q;
        cfg_err_d    = 1'b0;
        r_valid_d    = 1'b0;
        r_data_d     = r_data_q;
        r_ovf_d      = r_ovf_q;

        case (state_q)
            IDLE, READY: begin
                if (cfg_accept) begin
                    state_d      = CFG_SETUP;
                    cnt_d        = '0;
                    taps_d       = tap_count_i;
                    configured_d = 1'b0;
                    timeout_d    = 1'b0;
                end else begin
                    cfg_err_d = cfg_start_i;
                    if (take_sample) begin
                        state_d = SAMPLE;
                    end
                end
            end
            CFG_SETUP: begin
                if (cnt_q == CW'(1)) begin
                    state_d = CFG_HDR;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            CFG_HDR: begin
                state_d = CFG_COEF;
                cnt_d   = '0;
            end
            CFG_COEF: begin
                if (cnt_q == CW'(taps_q) - CW'(1)) begin
                    state_d = CFG_GUARD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            CFG_GUARD: begin
                if (cnt_q == CW'(1)) begin
                    state_d      = READY;
                    configured_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            SAMPLE: begin
                state_d = WAIT_DONE;
                cnt_d   = '0;
            end
            WAIT_DONE: begin
                if (fir_done_i) begin
                    state_d   = RESULT;
                    r_valid_d = 1'b1;
                    r_data_d  = fir_data_out_i;
                    r_ovf_d   = fir_overflow_flag_i;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d   = READY;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RESULT: begin
                state_d = READY;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FIR pins are decoded from the next state so that the registered
    // outputs line up with the state they belong to.
    always_comb begin
        cfg_d = 1'b0;
        cde_d = 1'b0;
        en_d  = 1'b0;
        din_d = 8'h00;
        case (state_d)
            CFG_SETUP: begin
                cfg_d = 1'b1;
            end
            CFG_HDR: begin
                cfg_d = 1'b1;
                cde_d = 1'b1;
                din_d = 8'(taps_d - 5'd1);
            end
            CFG_COEF: begin
                cfg_d = 1'b1;
                cde_d = 1'b1;
                din_d = coef_buf_q[cnt_d[AW-1:0]];
            end
            SAMPLE: begin
                en_d  = 1'b1;
                din_d = s_data_i;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            taps_q       <= '0;
            configured_q <= 1'b0;
            timeout_q    <= 1'b0;
            cfg_err_q    <= 1'b0;
            r_valid_q    <= 1'b0;
            r_data_q     <= '0;
            r_ovf_q      <= '0;
            din_q        <= '0;
            en_q         <= 1'b0;
            cfg_q        <= 1'b0;
            cde_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            taps_q       <= taps_d;
            configured_q <= configured_d;
            timeout_q    <= timeout_d;
            cfg_err_q    <= cfg_err_d;
            r_valid_q    <= r_valid_d;
            r_data_q     <= r_data_d;
            r_ovf_q      <= r_ovf_d;
            din_q        <= din_d;
            en_q         <= en_d;
            cfg_q        <= cfg_d;
            cde_q        <= cde_d;
        end
    end

    assign s_ready_o                = (state_q == READY);
    assign fir_data_in_o            = din_q;
    assign fir_enable_o             = en_q;
    assign fir_configuration_o      = cfg_q;
    assign fir_config_data_enable_o = cde_q;
    assign r_valid_o                = r_valid_q;
    assign r_data_o                 = r_data_q;
    assign r_ovf_o                  = r_ovf_q;
    assign configured_o             = configured_q;
    assign cfg_err_o                = cfg_err_q;
    assign timeout_err_o            = timeout_q;

endmodule

// File: tb/tb_fir_host_driver.sv
// ----------------------------------------------------------------------------
// tb_fir_host_driver
//
// Drives fir_host_driver with coefficient writes, configuration requests and
// randomized samples. A small FIR core stand-in answers each enable after a
// chosen delay; expected results and burst beats are queued at issue time and
// popped by independent monitors when the driver presents them.
// ----------------------------------------------------------------------------
module tb_fir_host_driver;

    localparam int MAX_TAPS = 16;
    localparam int AW       = 4;
    localparam int TIMEOUT  = 255;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          coefWe = 1'b0;
    logic [AW-1:0] coefAddr = '0;
    logic [7:0]    coefWdata = '0;
    logic [4:0]    tapCount = '0;
    logic          cfgStart = 1'b0;
    logic          sValid = 1'b0;
    logic [7:0]    sData = '0;
    logic          sReady;
    logic [7:0]    firDataIn;
    logic          firEnable;
    logic          firConfiguration;
    logic          firCde;
    logic [7:0]    firDataOut = '0;
    logic [1:0]    firOvf = '0;
    logic          firDone = 1'b0;
    logic          rValid;
    logic [7:0]    rData;
    logic [1:0]    rOvf;
    logic          configured;
    logic          cfgErr;
    logic          timeoutErr;

    typedef struct {
        logic [7:0] sample;
        int         delay;
        logic [7:0] resp;
        logic [1:0] ovf;
        bit         glitch;
    } firItem_t;

    typedef struct {
        logic [7:0] data;
        logic [1:0] ovf;
    } result_t;

    firItem_t   firQ[$];
    result_t    resQ[$];
    logic [7:0] cfgQ[$];
    logic [7:0] bufModel [MAX_TAPS];

    int vectors     = 0;
    int miscompares = 0;
    bit inFlight    = 1'b0;

    fir_host_driver #(
        .MAX_TAPS(MAX_TAPS),
        .AW      (AW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .coef_we_i               (coefWe),
        .coef_addr_i             (coefAddr),
        .coef_wdata_i            (coefWdata),
        .tap_count_i             (tapCount),
        .cfg_start_i             (cfgStart),
        .s_valid_i               (sValid),
        .s_data_i                (sData),
        .s_ready_o               (sReady),
        .fir_data_in_o           (firDataIn),
        .fir_enable_o            (firEnable),
        .fir_configuration_o     (firConfiguration),
        .fir_config_data_enable_o(firCde),
        .fir_data_out_i          (firDataOut),
        .fir_overflow_flag_i     (firOvf),
        .fir_done_i              (firDone),
        .r_valid_o               (rValid),
        .r_data_o                (rData),
        .r_ovf_o                 (rOvf),
        .configured_o            (configured),
        .cfg_err_o               (cfgErr),
        .timeout_err_o           (timeoutErr)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)",
                     name, actual, expected, $time);
        end
    endtask

    // FIR core stand-in: on each enable it takes the next planned answer,
    // optionally pulses a bogus done during the enable cycle, then raises
    // done with the planned data after the planned delay.
    initial begin
        firItem_t it;
        forever begin
            @(negedge clk);
            if (firEnable === 1'b1) begin
                if (firQ.size() == 0) begin
                    checkOutput("unexpected fir_enable", 1, 0);
                    continue;
                end
                it = firQ.pop_front();
                checkOutput("fir_data_in at enable", firDataIn, it.sample);
                checkOutput("enable while busy", inFlight, 0);
                inFlight = 1'b1;
                if (it.glitch) begin
                    firDone    = 1'b1;
                    firDataOut = ~it.resp;
                    firOvf     = 2'b11;
                end
                if (it.delay >= 0) begin
                    repeat (it.delay) begin
                        @(negedge clk);
                        firDone = 1'b0;
                    end
                    @(negedge clk);
                    firDone    = 1'b1;
                    firDataOut = it.resp;
                    firOvf     = it.ovf;
                end
                @(negedge clk);
                firDone = 1'b0;
            end
        end
    end

    // Output monitor: results and burst beats are popped as the driver
    // presents them, and pin-level rules are watched every cycle.
    initial begin
        result_t    exp;
        logic [7:0] beat;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                if (rValid === 1'b1) begin
                    checkOutput("s_ready during r_valid", sReady, 0);
                    if (resQ.size() == 0) begin
                        checkOutput("unexpected r_valid", 1, 0);
                    end else begin
                        exp = resQ.pop_front();
                        checkOutput("r_data", rData, exp.data);
                        checkOutput("r_ovf", rOvf, exp.ovf);
                    end
                    inFlight = 1'b0;
                end
                if (firCde === 1'b1) begin
                    checkOutput("configuration during burst", firConfiguration, 1);
                    if (cfgQ.size() == 0) begin
                        checkOutput("unexpected burst beat", 1, 0);
                    end else begin
                        beat = cfgQ.pop_front();
                        checkOutput("burst data_in", firDataIn, beat);
                    end
                end
                if (firEnable === 1'b1) begin
                    checkOutput("s_ready during enable", sReady, 0);
                end
                if (firEnable !== 1'b1 && firCde !== 1'b1) begin
                    checkOutput("idle data_in", firDataIn, 0);
                end
            end
        end
    end

    task automatic writeCoef(input int addr, input logic [7:0] data);
        @(negedge clk);
        coefWe    = 1'b1;
        coefAddr  = AW'(addr);
        coefWdata = data;
        bufModel[addr] = data;
    endtask

    // Configuration request; abortAt > 0 pulls reset during that cycle.
    task automatic applyCfg(input int taps, input bit scribble, input int abortAt);
        @(negedge clk);
        coefWe   = 1'b0;
        tapCount = taps[4:0];
        cfgStart = 1'b1;
        cfgQ.push_back(8'(taps - 1));
        for (int k = 0; k < taps; k++) cfgQ.push_back(bufModel[k]);
        @(negedge clk);
        cfgStart = 1'b0;
        checkOutput("setup configuration", firConfiguration, 1);
        checkOutput("setup cde", firCde, 0);
        checkOutput("configured cleared", configured, 0);
        checkOutput("timeout_err cleared", timeoutErr, 0);
        checkOutput("s_ready in config", sReady, 0);
        for (int i = 2; i <= taps + 6; i++) begin
            @(negedge clk);
            if (i == abortAt) begin
                coefWe = 1'b0;
                #2 rst_n = 1'b0;
                #1;
                checkOutput("reset drops configuration", firConfiguration, 0);
                checkOutput("reset drops cde", firCde, 0);
                checkOutput("reset clears configured", configured, 0);
                cfgQ.delete();
                return;
            end
            coefWe = scribble && (i >= 3) && (i <= taps + 3);
            if (coefWe) begin
                coefAddr  = AW'($urandom_range(0, taps - 1));
                coefWdata = 8'($urandom);
            end
            if (i == 2) checkOutput("setup 2nd cycle cde", firCde, 0);
            if (i == taps + 4) begin
                checkOutput("guard configuration", firConfiguration, 0);
                checkOutput("guard cde", firCde, 0);
            end
            if (i == taps + 5) checkOutput("configured before end", configured, 0);
            if (i == taps + 6) begin
                checkOutput("configured at end", configured, 1);
                checkOutput("s_ready at end", sReady, 1);
            end
        end
        coefWe = 1'b0;
        checkOutput("burst beats left", cfgQ.size(), 0);
    endtask

    task automatic applyBadCfg(input int taps, input bit expConfigured);
        @(negedge clk);
        tapCount = taps[4:0];
        cfgStart = 1'b1;
        @(negedge clk);
        cfgStart = 1'b0;
        checkOutput("cfg_err pulse", cfgErr, 1);
        checkOutput("no configuration on reject", firConfiguration, 0);
        checkOutput("configured kept on reject", configured, expConfigured);
        @(negedge clk);
        checkOutput("cfg_err one cycle", cfgErr, 0);
        checkOutput("no cde on reject", firCde, 0);
    endtask

    // Offers one sample (leaving s_valid high) and returns at the accepting edge.
    task automatic applyStimulus(input logic [7:0] sample, input int delay,
                                 input logic [7:0] resp, input logic [1:0] ovf,
                                 input bit glitch);
        firItem_t it;
        result_t  r;
        int       waitCycles;
        it.sample = sample;
        it.delay  = delay;
        it.resp   = resp;
        it.ovf    = ovf;
        it.glitch = glitch;
        firQ.push_back(it);
        if (delay >= 0) begin
            r.data = resp;
            r.ovf  = ovf;
            resQ.push_back(r);
        end
        @(negedge clk);
        sValid = 1'b1;
        sData  = sample;
        waitCycles = 0;
        while (sReady !== 1'b1 && waitCycles < 600) begin
            @(negedge clk);
            waitCycles++;
        end
        if (sReady !== 1'b1) begin
            checkOutput("s_ready wait", 0, 1);
            sValid = 1'b0;
            void'(firQ.pop_back());
            if (delay >= 0) void'(resQ.pop_back());
            return;
        end
        @(posedge clk);
    endtask

    task automatic applyRandomSamples(input int n);
        for (int k = 0; k < n; k++) begin
            applyStimulus(8'($urandom), int'($urandom_range(0, 30)), 8'($urandom),
                          2'($urandom_range(0, 2)), ($urandom_range(0, 3) == 0));
        end
        @(negedge clk);
        sValid = 1'b0;
    endtask

    task automatic waitDrain();
        int n = 0;
        while ((resQ.size() != 0 || firQ.size() != 0 || sReady !== 1'b1) && n < 800) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain", (resQ.size() == 0 && firQ.size() == 0 && sReady === 1'b1), 1);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        checkOutput("reset s_ready", sReady, 0);
        checkOutput("reset fir_data_in", firDataIn, 0);
        checkOutput("reset fir_enable", firEnable, 0);
        checkOutput("reset fir_configuration", firConfiguration, 0);
        checkOutput("reset fir_cde", firCde, 0);
        checkOutput("reset r_valid", rValid, 0);
        checkOutput("reset r_data", rData, 0);
        checkOutput("reset r_ovf", rOvf, 0);
        checkOutput("reset configured", configured, 0);
        checkOutput("reset cfg_err", cfgErr, 0);
        checkOutput("reset timeout_err", timeoutErr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("idle s_ready", sReady, 0);

        $display("[TB] configure 10 taps of 0x39");
        for (int k = 0; k < MAX_TAPS; k++) writeCoef(k, (k < 10) ? 8'h39 : 8'($urandom));
        applyCfg(10, 1'b0, 0);

        $display("[TB] single sample 0xC0");
        applyStimulus(8'hC0, 19, 8'h1E, 2'b00, 1'b0);
        @(negedge clk);
        sValid = 1'b0;
        waitDrain();

        $display("[TB] back-to-back random samples");
        applyRandomSamples(16);
        waitDrain();

        $display("[TB] FIR never answers");
        applyStimulus(8'($urandom), -1, 8'h00, 2'b00, 1'b0);
        n = 0;
        while (timeoutErr !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
            if (n == 1) sValid = 1'b0;
        end
        checkOutput("timeout latency", n, TIMEOUT + 2);
        checkOutput("s_ready after timeout", sReady, 1);
        inFlight = 1'b0;
        @(negedge clk);
        checkOutput("timeout_err sticky", timeoutErr, 1);

        $display("[TB] 16-tap burst with blocked writes, then rejects");
        for (int k = 0; k < MAX_TAPS; k++) writeCoef(k, 8'($urandom));
        applyCfg(16, 1'b1, 0);
        applyCfg(16, 1'b0, 0);
        applyBadCfg(0, 1'b1);
        applyBadCfg(17, 1'b1);
        applyCfg(1, 1'b0, 0);
        applyRandomSamples(4);
        waitDrain();

        $display("[TB] reset during coefficient burst");
        applyCfg(12, 1'b0, 8);
        inFlight = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("configured after reset", configured, 0);
        checkOutput("idle after reset", sReady, 0);
        sValid = 1'b1;
        sData  = 8'h55;
        repeat (5) @(negedge clk);
        checkOutput("no sample in idle", sReady, 0);
        checkOutput("no configuration in idle", firConfiguration, 0);
        sValid = 1'b0;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        miscompares++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "[TB] aborted");
    end

endmodule
